sigma_delta_mod_pd: RTL and testbench

- Parametrised 1-bit sigma-delta modulator; next generation of the team's fixed 32-bit first-order sigmadel.
- Adds runtime-selectable first/second order, a clock-divided modulator step rate, and a double-buffered valid/ready sample input.
- Adds saturating integrators with a sticky overflow flag.
- Feeds a 1-bit DAC/PWM pin; upstream is any sample producer in the clk domain.

---
 rtl/sigma_delta_mod_pd.sv | 232 +++++++++++++++++++++++
 tb/tb_sigma_delta_mod_pd.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_mod_pd.sv
// -----------------------------------------------------------------------------
// sigma_delta_mod_pd
//
// 1-bit sigma-delta modulator driving a DAC/PWM pin. Runtime-selectable first
// or second order, a clock-divided step rate and a double-buffered sample
// input. The second-order integrators saturate and raise a sticky flag.
//
// Parameters:
//   WIDTH - unsigned input sample width (>= 2)
//   IW    - signed integrator width used in second-order mode (>= WIDTH+2)
//   DIV   - modulator step period in clk cycles (>= 1)
//
// Ports:
//   clk        in   system clock, everything on posedge
//   rst        in   synchronous, active-low reset
//   en         in   step enable; 0 freezes divider, integrators and dout
//   mode       in   0 = first order, 1 = second order
//   din        in   [WIDTH-1:0] unsigned sample
//   din_valid  in   sample present
//   din_ready  out  hold register empty
//   dout       out  registered modulator bitstream
//   ovf        out  sticky integrator-saturation flag
//   clr_ovf    in   clears ovf (a coincident saturation wins)
//
// Optional feature (macro SD_DITHER_EN): a 16-bit Fibonacci LFSR
// (x^16+x^14+x^13+x^11+1, seed 16'hACE1) adds its bit 0 to the sample on
// every step, saturating at full scale. Undefined: no LFSR is built.
//
// Handshake: a transfer happens on any posedge where din_valid and din_ready
// are both high; din_ready is a registered ~hold_full and does not depend on
// din_valid. The held sample moves to the modulator on the next step tick,
// which frees the hold register for the following cycle. The handshake runs
// whether or not en is high.
// -----------------------------------------------------------------------------
module sigma_delta_mod_pd #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IW    = WIDTH + 4,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  // Two guard bits keep i + sample - fb exact before saturation.
  localparam int unsigned EW = IW + 2;

  localparam logic [CW-1:0]        CNT_LAST = CW'(DIV - 1);
  localparam logic signed [EW-1:0] SAT_MAX  = {3'b000, {(IW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN  = {3'b111, {(IW-1){1'b0}}};
  localparam logic signed [EW-1:0] FB_FULL  =
    {{(EW-WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  logic [WIDTH-1:0]     acc1_q, acc1_d;
  logic signed [IW-1:0] i1_q, i1_d;
  logic signed [IW-1:0] i2_q, i2_d;
  logic [WIDTH-1:0]     sample_q, sample_d;
  logic [WIDTH-1:0]     hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 dout_q, dout_d;
  logic                 ovf_q, ovf_d;

  logic                 mode_chg;
  logic                 tick;
  logic                 accept;
  logic [WIDTH-1:0]     sample_eff;

  logic [WIDTH:0]       m0_sum;
  logic signed [EW-1:0] fb;
  logic signed [EW-1:0] smp_ext;
  logic signed [EW-1:0] i1_sum;
  logic signed [EW-1:0] i2_sum;
  logic signed [IW-1:0] i1_n;
  logic signed [IW-1:0] i2_n;
  logic                 clamp1;
  logic                 clamp2;

  assign din_ready = ~hold_full_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

  // A mode change restarts the modulator and suppresses any step that cycle.
  assign mode_chg = (mode != mode_q);
  assign tick     = en & (cnt_q == CNT_LAST) & ~mode_chg;
  assign accept   = din_valid & ~hold_full_q;

`ifdef SD_DITHER_EN
  logic [15:0]    lfsr_q, lfsr_d;
  logic [WIDTH:0] dith_sum;

  always_comb begin
    dith_sum   = {1'b0, sample_q} + {{WIDTH{1'b0}}, lfsr_q[0]};
    sample_eff = dith_sum[WIDTH] ? {WIDTH{1'b1}} : dith_sum[WIDTH-1:0];
    lfsr_d     = lfsr_q;
    if (tick) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign sample_eff = sample_q;
`endif

  // Datapath candidates for both orders; the step logic picks one.
  always_comb begin
    m0_sum  = {1'b0, acc1_q} + {1'b0, sample_eff};
    fb      = dout_q ? FB_FULL : '0;
    smp_ext = $signed({{(EW-WIDTH){1'b0}}, sample_eff});

    clamp1 = 1'b0;
    i1_sum = $signed({{2{i1_q[IW-1]}}, i1_q}) + smp_ext - fb;
    if (i1_sum > SAT_MAX) begin
      i1_n   = SAT_MAX[IW-1:0];
      clamp1 = 1'b1;
    end else if (i1_sum < SAT_MIN) begin
      i1_n   = SAT_MIN[IW-1:0];
      clamp1 = 1'b1;
    end else begin
      i1_n = i1_sum[IW-1:0];
    end

    clamp2 = 1'b0;
    i2_sum = $signed({{2{i2_q[IW-1]}}, i2_q}) + $signed({{2{i1_n[IW-1]}}, i1_n}) - fb;
    if (i2_sum > SAT_MAX) begin
      i2_n   = SAT_MAX[IW-1:0];
      clamp2 = 1'b1;
    end else if (i2_sum < SAT_MIN) begin
      i2_n   = SAT_MIN[IW-1:0];
      clamp2 = 1'b1;
    end else begin
      i2_n = i2_sum[IW-1:0];
    end
  end

  // Next-state: divider, modulator step, mode restart, ovf and handshake.
  always_comb begin
    acc1_d      = acc1_q;
    i1_d        = i1_q;
    i2_d        = i2_q;
    sample_d    = sample_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;

    if (mode_chg) begin
      mode_d = mode;
      acc1_d = '0;
      i1_d   = '0;
      i2_d   = '0;
      cnt_d  = '0;
      dout_d = 1'b0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    if (tick) begin
      if (!mode_q) begin
        // First order: the carry out of the wrapping accumulator is the bit.
        acc1_d = m0_sum[WIDTH-1:0];
        dout_d = m0_sum[WIDTH];
      end else begin
        i1_d   = i1_n;
        i2_d   = i2_n;
        dout_d = ~i2_n[IW-1] & (|i2_n);
      end
    end

    // Saturation has priority over a simultaneous clear.
    if (tick && mode_q && (clamp1 || clamp2)) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end

    // The step above used the previous sample_q; the held sample lands now.
    if (tick && hold_full_q) begin
      sample_d    = hold_q;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc1_q      <= '0;
      i1_q        <= '0;
      i2_q        <= '0;
      sample_q    <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      dout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      acc1_q      <= acc1_d;
      i1_q        <= i1_d;
      i2_q        <= i2_d;
      sample_q    <= sample_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sigma_delta_mod_pd.sv
// -----------------------------------------------------------------------------
// Testbench for sigma_delta_mod_pd. Three instances share the input stimulus:
//   dut_a: WIDTH=4, IW=8, DIV=1
//   dut_b: WIDTH=4, IW=8, DIV=4
//   dut_c: WIDTH=4, IW=6, DIV=1
// Each test resets everything and then observes one instance (sel). A
// cycle-level integer model predicts {din_ready, ovf, dout}; predictions go
// into exp_q before the clock edge and are popped and compared after it.
// -----------------------------------------------------------------------------
module tb_sigma_delta_mod_pd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [3:0] din = 4'd0;
  logic       din_valid = 1'b0;
  logic       clr_ovf = 1'b0;

  logic a_ready, a_dout, a_ovf;
  logic b_ready, b_dout, b_ovf;
  logic c_ready, c_dout, c_ovf;
  logic o_ready, o_dout, o_ovf;

  int sel = 0;
  int checks = 0;
  int failures = 0;

  logic [2:0] exp_q[$];

  // Reference model state
  int m_div = 1;
  int m_iw = 8;
  int m_acc, m_i1, m_i2, m_samp, m_hold, m_cnt, m_mode;
  bit m_full, m_ovf, m_dout, m_clamp;

  always #5 clk = ~clk;

  sigma_delta_mod_pd #(.WIDTH(4), .IW(8), .DIV(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .din_valid(din_valid), .din_ready(a_ready), .dout(a_dout),
    .ovf(a_ovf), .clr_ovf(clr_ovf));

  sigma_delta_mod_pd #(.WIDTH(4), .IW(8), .DIV(4)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .din_valid(din_valid), .din_ready(b_ready), .dout(b_dout),
    .ovf(b_ovf), .clr_ovf(clr_ovf));

  sigma_delta_mod_pd #(.WIDTH(4), .IW(6), .DIV(1)) dut_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .din(din),
    .din_valid(din_valid), .din_ready(c_ready), .dout(c_dout),
    .ovf(c_ovf), .clr_ovf(clr_ovf));

  assign o_ready = (sel == 0) ? a_ready : (sel == 1) ? b_ready : c_ready;
  assign o_dout  = (sel == 0) ? a_dout  : (sel == 1) ? b_dout  : c_dout;
  assign o_ovf   = (sel == 0) ? a_ovf   : (sel == 1) ? b_ovf   : c_ovf;

  // One clock of the reference model, using the inputs as they stand now.
  task automatic model_cycle();
    int  lo, hi, fb, a, b, t;
    bit  mchg, tick, acc;
    m_clamp = 1'b0;
    if (rst == 1'b0) begin
      m_acc = 0; m_i1 = 0; m_i2 = 0; m_samp = 0; m_hold = 0; m_cnt = 0;
      m_mode = 0; m_full = 1'b0; m_ovf = 1'b0; m_dout = 1'b0;
      return;
    end
    lo   = -(1 << (m_iw - 1));
    hi   = (1 << (m_iw - 1)) - 1;
    mchg = (int'(mode) != m_mode);
    tick = en && (m_cnt == m_div - 1) && !mchg;
    acc  = din_valid && !m_full;
    if (mchg) begin
      m_mode = int'(mode);
      m_acc = 0; m_i1 = 0; m_i2 = 0; m_cnt = 0; m_dout = 1'b0;
    end else if (en) begin
      m_cnt = (m_cnt == m_div - 1) ? 0 : m_cnt + 1;
    end
    if (tick) begin
      if (m_mode == 0) begin
        t      = m_acc + m_samp;
        m_dout = (t >= 16);
        m_acc  = t % 16;
      end else begin
        fb = m_dout ? 16 : 0;
        a  = m_i1 + m_samp - fb;
        if (a > hi) begin a = hi; m_clamp = 1'b1; end
        if (a < lo) begin a = lo; m_clamp = 1'b1; end
        b  = m_i2 + a - fb;
        if (b > hi) begin b = hi; m_clamp = 1'b1; end
        if (b < lo) begin b = lo; m_clamp = 1'b1; end
        m_i1   = a;
        m_i2   = b;
        m_dout = (b > 0);
      end
    end
    if (m_clamp) m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (tick && m_full) begin
      m_samp = m_hold;
      m_full = 1'b0;
    end
    if (acc) begin
      m_hold = int'(din);
      m_full = 1'b1;
    end
  endtask

  // Drive one clock: predict, push, clock, pop and compare.
  task automatic cyc();
    logic [2:0] e;
    model_cycle();
    exp_q.push_back({~m_full, m_ovf, m_dout});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (o_dout !== e[0]) begin
      failures++;
      $display("FAIL sb_dout sel=%0d t=%0t got=%b exp=%b", sel, $time, o_dout, e[0]);
    end
    checks++;
    if (o_ovf !== e[1]) begin
      failures++;
      $display("FAIL sb_ovf sel=%0d t=%0t got=%b exp=%b", sel, $time, o_ovf, e[1]);
    end
    checks++;
    if (o_ready !== e[2]) begin
      failures++;
      $display("FAIL sb_ready sel=%0d t=%0t got=%b exp=%b", sel, $time, o_ready, e[2]);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    sel = 0; m_div = 1; m_iw = 8;
    en = 1'b1; mode = 1'b0; din = 4'd5; din_valid = 1'b1; clr_ovf = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++;
      if (o_dout !== 1'b0 || o_ready !== 1'b1 || o_ovf !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got dout=%b ready=%b ovf=%b exp 0/1/0",
                 i, o_dout, o_ready, o_ovf);
      end
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (o_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_first_accept got ready=%b exp=0", o_ready);
    end
  endtask

  task automatic test_mode0_density();
    int tbl_din[3]  = '{4, 0, 15};
    int tbl_win[3]  = '{64, 32, 16};
    int tbl_ones[3] = '{16, 0, 15};
    int ones;
    sel = 0; m_div = 1; m_iw = 8;
    for (int k = 0; k < 3; k++) begin
      en = 1'b1; mode = 1'b0; din = 4'(tbl_din[k]); din_valid = 1'b1;
      do_reset(3);
      repeat (8) cyc();
      ones = 0;
      repeat (tbl_win[k]) begin
        cyc();
        ones += int'(o_dout);
      end
      checks++;
      if (ones != tbl_ones[k]) begin
        failures++;
        $display("FAIL m0_density din=%0d got=%0d exp=%0d", tbl_din[k], ones, tbl_ones[k]);
      end
    end
  endtask

  task automatic test_divider_freeze();
    int   ones, trans;
    logic prev;
    sel = 1; m_div = 4; m_iw = 8;
    en = 1'b1; mode = 1'b0; din = 4'd8; din_valid = 1'b1;
    do_reset(3);
    repeat (22) cyc();
    en = 1'b0;
    repeat (10) cyc();
    en = 1'b1;
    prev = o_dout;
    ones = 0; trans = 0;
    repeat (64) begin
      cyc();
      ones += int'(o_dout);
      if (o_dout != prev) trans++;
      prev = o_dout;
    end
    checks++;
    if (ones != 32) begin
      failures++;
      $display("FAIL div4_ones got=%0d exp=32", ones);
    end
    checks++;
    if (trans != 16) begin
      failures++;
      $display("FAIL div4_transitions got=%0d exp=16", trans);
    end
  endtask

  task automatic test_back_to_back();
    int   seq[3] = '{3, 7, 11};
    int   idx, ncyc;
    logic pre;
    sel = 1; m_div = 4; m_iw = 8;
    en = 1'b1; mode = 1'b0; din_valid = 1'b0; din = 4'd0;
    do_reset(3);
    din = 4'(seq[0]); din_valid = 1'b1;
    idx = 0; ncyc = 0;
    while (idx < 3 && ncyc < 200) begin
      pre = o_ready;
      cyc();
      ncyc++;
      if (pre) begin
        idx++;
        if (idx < 3) din = 4'(seq[idx]);
        else din_valid = 1'b0;
      end
    end
    checks++;
    if (idx != 3) begin
      failures++;
      $display("FAIL b2b_timeout accepts=%0d exp=3", idx);
    end
    checks++;
    if (ncyc != 9) begin
      failures++;
      $display("FAIL b2b_cycles got=%0d exp=9", ncyc);
    end
    repeat (40) cyc();
    checks++;
    if (o_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready_idle got=%b exp=1", o_ready);
    end
  endtask

  task automatic test_mode1();
    int ones;
    sel = 0; m_div = 1; m_iw = 8;
    en = 1'b1; mode = 1'b1; din = 4'd8; din_valid = 1'b1;
    do_reset(3);
    repeat (16) cyc();
    ones = 0;
    repeat (256) begin
      cyc();
      ones += int'(o_dout);
    end
    checks++;
    if (ones < 126 || ones > 130) begin
      failures++;
      $display("FAIL m1_density got=%0d exp=128+-2", ones);
    end
    mode = 1'b0;
    cyc();
    checks++;
    if (o_dout !== 1'b0) begin
      failures++;
      $display("FAIL m1_to_m0_dout got=%b exp=0", o_dout);
    end
    repeat (32) cyc();
  endtask

  task automatic test_overflow();
    sel = 2; m_div = 1; m_iw = 6;
    en = 1'b1; mode = 1'b1; din = 4'd15; din_valid = 1'b1; clr_ovf = 1'b0;
    do_reset(3);
    repeat (200) cyc();
    checks++;
    if (o_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set got=%b exp=1", o_ovf);
    end
    en = 1'b0; clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    checks++;
    if (o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear got=%b exp=0", o_ovf);
    end
    en = 1'b1; clr_ovf = 1'b1;
    repeat (60) begin
      cyc();
      if (m_clamp) begin
        checks++;
        if (o_ovf !== 1'b1) begin
          failures++;
          $display("FAIL ovf_set_over_clr got=%b exp=1", o_ovf);
        end
      end
    end
    clr_ovf = 1'b0;
    repeat (4) cyc();
  endtask

  initial begin
    test_reset();
    test_mode0_density();
    test_divider_freeze();
    test_back_to_back();
    test_mode1();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t exp=finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
